// File: rtl/fu_issue_arbiter_if.sv
// Bundle between the issue arbiter, its reservation stations, the shared FU and one CDB lane.
// The slave modport is the arbiter's view; master is the environment's view.
interface fu_issue_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int ROB_DEPTH = 4
);
    localparam int TW = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;

    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0][31:0]   instr;
    logic [N_REQ-1:0][TW-1:0] tag;
    logic [N_REQ-1:0][31:0]   a;
    logic [N_REQ-1:0][31:0]   b;
    logic [N_REQ-1:0]         resp;

    logic                     fu_start;
    logic [31:0]              fu_instr;
    logic [31:0]              fu_a;
    logic [31:0]              fu_b;
    logic                     fu_done;
    logic [31:0]              fu_result;

    logic                     cdb_valid;
    logic [TW-1:0]            cdb_tag;
    logic [31:0]              cdb_data;
    logic                     cdb_ack;
    logic                     busy;

    modport slave (
        input  req, instr, tag, a, b, fu_done, fu_result, cdb_ack,
        output resp, fu_start, fu_instr, fu_a, fu_b, cdb_valid, cdb_tag, cdb_data, busy
    );

    modport master (
        output req, instr, tag, a, b, fu_done, fu_result, cdb_ack,
        input  resp, fu_start, fu_instr, fu_a, fu_b, cdb_valid, cdb_tag, cdb_data, busy
    );
endinterface

// File: rtl/fu_issue_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FU among N_REQ reservation stations;
// one op in flight, result returned on a single CDB lane, resp pulsed on CDB accept.
module fu_issue_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ROB_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    fu_issue_arbiter_if.slave   bus
);
    localparam int TW = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] g_q, g_d;
    logic [GW-1:0] rr_q, rr_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [31:0]   res_q, res_d;
    logic [TW-1:0] tag_q, tag_d;

    logic          kill;
    logic [GW-1:0] pick;
    logic          pick_vld;
    logic [N_REQ-1:0] resp_o;

    assign kill = rst | flush;

    // First requester at or above rr_q, wrapping modulo N_REQ.
    always_comb begin
        int            cand_i;
        logic [GW-1:0] cand;
        pick     = '0;
        pick_vld = 1'b0;
        cand_i   = 0;
        cand     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_i = int'(rr_q) + k;
            if (cand_i >= N_REQ) cand_i = cand_i - N_REQ;
            cand = GW'(cand_i);
            if (!pick_vld && bus.req[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        rr_d    = rr_q;
        instr_d = instr_q;
        a_d     = a_q;
        b_d     = b_q;
        tag_d   = tag_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    g_d     = pick;
                    instr_d = bus.instr[pick];
                    a_d     = bus.a[pick];
                    b_d     = bus.b[pick];
                    tag_d   = bus.tag[pick];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.fu_done) begin
                    res_d   = bus.fu_result;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (bus.cdb_ack) begin
                    rr_d    = (g_q == GW'(N_REQ - 1)) ? '0 : g_q + GW'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            instr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            instr_q <= instr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
        end
    end

    // A same-cycle rst/flush aborts the op, so it must also suppress the resp pulse.
    always_comb begin
        resp_o = '0;
        if (state_q == S_WB && bus.cdb_ack && !kill) resp_o[g_q] = 1'b1;
    end

    assign bus.resp      = resp_o;
    assign bus.fu_start  = (state_q == S_ISSUE) && !kill;
    assign bus.fu_instr  = instr_q;
    assign bus.fu_a      = a_q;
    assign bus.fu_b      = b_q;
    assign bus.cdb_valid = (state_q == S_WB) && !kill;
    assign bus.cdb_tag   = tag_q;
    assign bus.cdb_data  = (state_q == S_WB) ? res_q : 32'd0;
    assign bus.busy      = (state_q != S_IDLE);
endmodule
